// File: rtl/pe_pkg.sv
// pe_pkg: shared types and helpers for the pe_mac_pool processing element.
// Holds the FSM state and job mode enums plus the saturating adder used by
// the convolution datapath.
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2,
    OUTPUT  = 2'd3
  } pe_state_e;

  typedef enum logic {
    MODE_CONV = 1'b0,
    MODE_POOL = 1'b1
  } pe_mode_e;

  // Adds two sign-extended operands and clamps the sum to the signed range of
  // a w-bit accumulator. Operands are carried in 64 bits so the raw sum can
  // never wrap before the clamp is applied.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] sum;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    sum   = a + b;
    max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (w - 1));
    if (sum > max_v)      return max_v;
    else if (sum < min_v) return min_v;
    else                  return sum;
  endfunction

endpackage

// File: rtl/pe_mac_pool_if.sv
// pe_mac_pool_if: descriptor, operand and result channels of the processing
// element. master = job producer/result consumer, slave = the PE itself.
interface pe_mac_pool_if #(
  parameter int DATA_WIDTH = 8,
  parameter int SPAD_DEPTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(SPAD_DEPTH),
  parameter int LEN_W      = $clog2(SPAD_DEPTH + 1)
);
  logic                        cfg_valid;
  logic                        cfg_ready;
  logic                        cfg_mode;
  logic [LEN_W-1:0]            cfg_len;
  logic                        cfg_keep_wt;
  logic signed [ACC_WIDTH-1:0] cfg_bias;
  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       actn_in;
  logic [DATA_WIDTH-1:0]       filt_in;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [ACC_WIDTH-1:0] pe_out;
  logic                        pe_busy;
  logic                        cfg_err;

  modport master (
    output cfg_valid, cfg_mode, cfg_len, cfg_keep_wt, cfg_bias,
    output in_valid, actn_in, filt_in, out_ready,
    input  cfg_ready, in_ready, out_valid, pe_out, pe_busy, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_mode, cfg_len, cfg_keep_wt, cfg_bias,
    input  in_valid, actn_in, filt_in, out_ready,
    output cfg_ready, in_ready, out_valid, pe_out, pe_busy, cfg_err
  );
endinterface

// File: rtl/pe_scratchpad.sv
// pe_scratchpad: small local buffer with one synchronous write port and one
// combinational read port, so consecutive reads need no bubble. Contents
// are intentionally not reset.
module pe_scratchpad #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Store one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/pe_mac_pool.sv
// pe_mac_pool: processing element that buffers len activation/weight pairs,
// then computes either a saturating signed MAC with bias (conv) or a running
// maximum (pool), and returns one result per job.
// Optional build macro PE_RELU_EN: clamps negative conv results to zero.
module pe_mac_pool
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SPAD_DEPTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(SPAD_DEPTH),
  parameter int LEN_W      = $clog2(SPAD_DEPTH + 1)
) (
  input logic          clk,
  input logic          rst,
  pe_mac_pool_if.slave bus
);
  localparam int AW = (SPAD_DEPTH > 1) ? $clog2(SPAD_DEPTH) : 1;
  localparam int PW = 2*DATA_WIDTH;

  pe_state_e                   state_reg, state_next;
  pe_mode_e                    mode_reg, mode_next;
  logic                        keep_reg, keep_next;
  logic [LEN_W-1:0]            len_reg, len_next;
  logic [LEN_W-1:0]            wr_ptr_reg, wr_ptr_next;
  logic [LEN_W-1:0]            rd_ptr_reg, rd_ptr_next;
  logic [LEN_W-1:0]            wt_len_reg, wt_len_next;
  logic                        wt_valid_reg, wt_valid_next;
  logic signed [ACC_WIDTH-1:0] bias_reg, bias_next;
  logic signed [ACC_WIDTH-1:0] acc_reg, acc_next;
  logic                        cfg_err_reg, cfg_err_next;

  logic [DATA_WIDTH-1:0]       actn_rd, filt_rd;
  logic                        if_we, wt_we;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] acc_base, conv_acc, actn_ext, pool_acc, result;
  logic                        cfg_illegal;

  // Weights are only overwritten by a fresh conv load, so a stored filter
  // survives pool jobs and keep_wt jobs.
  assign if_we = (state_reg == LOAD) && bus.in_valid;
  assign wt_we = if_we && !keep_reg && (mode_reg == MODE_CONV);

  pe_scratchpad #(.WIDTH(DATA_WIDTH), .DEPTH(SPAD_DEPTH), .AW(AW)) if_spad (
    .clk(clk), .we(if_we), .wr_addr(wr_ptr_reg[AW-1:0]), .wr_data(bus.actn_in),
    .rd_addr(rd_ptr_reg[AW-1:0]), .rd_data(actn_rd)
  );

  pe_scratchpad #(.WIDTH(DATA_WIDTH), .DEPTH(SPAD_DEPTH), .AW(AW)) wt_spad (
    .clk(clk), .we(wt_we), .wr_addr(wr_ptr_reg[AW-1:0]), .wr_data(bus.filt_in),
    .rd_addr(rd_ptr_reg[AW-1:0]), .rd_data(filt_rd)
  );

  // Tap 0 seeds the accumulator (bias for conv, first activation for pool),
  // so no separate init cycle is needed.
  assign prod     = PW'($signed(actn_rd)) * PW'($signed(filt_rd));
  assign acc_base = (rd_ptr_reg == '0) ? bias_reg : acc_reg;
  assign conv_acc = ACC_WIDTH'(sat_add(64'(acc_base), 64'(prod), ACC_WIDTH));
  assign actn_ext = ACC_WIDTH'($signed(actn_rd));
  assign pool_acc = ((rd_ptr_reg == '0) || (actn_ext > acc_reg)) ? actn_ext : acc_reg;

  assign cfg_illegal = (bus.cfg_len == '0) ||
                       (bus.cfg_len > LEN_W'(SPAD_DEPTH)) ||
                       (bus.cfg_keep_wt && (!wt_valid_reg || (bus.cfg_len != wt_len_reg)));

`ifdef PE_RELU_EN
  assign result = ((mode_reg == MODE_CONV) && acc_reg[ACC_WIDTH-1]) ? '0 : acc_reg;
`else
  assign result = acc_reg;
`endif

  // Next-state and datapath update for the IDLE/LOAD/COMPUTE/OUTPUT sequence.
  always_comb begin
    state_next    = state_reg;
    mode_next     = mode_reg;
    keep_next     = keep_reg;
    len_next      = len_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    wt_len_next   = wt_len_reg;
    wt_valid_next = wt_valid_reg;
    bias_next     = bias_reg;
    acc_next      = acc_reg;
    cfg_err_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cfg_valid) begin
          if (cfg_illegal) begin
            cfg_err_next = 1'b1;
          end else begin
            mode_next   = pe_mode_e'(bus.cfg_mode);
            keep_next   = bus.cfg_keep_wt;
            len_next    = bus.cfg_len;
            bias_next   = bus.cfg_bias;
            wr_ptr_next = '0;
            state_next  = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          wr_ptr_next = wr_ptr_reg + LEN_W'(1);
          if (wr_ptr_reg == len_reg - LEN_W'(1)) begin
            rd_ptr_next = '0;
            state_next  = COMPUTE;
            if ((mode_reg == MODE_CONV) && !keep_reg) begin
              wt_valid_next = 1'b1;
              wt_len_next   = len_reg;
            end
          end
        end
      end
      COMPUTE: begin
        acc_next    = (mode_reg == MODE_CONV) ? conv_acc : pool_acc;
        rd_ptr_next = rd_ptr_reg + LEN_W'(1);
        if (rd_ptr_reg == len_reg - LEN_W'(1)) state_next = OUTPUT;
      end
      OUTPUT: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and job registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= MODE_CONV;
      keep_reg     <= 1'b0;
      len_reg      <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      wt_len_reg   <= '0;
      wt_valid_reg <= 1'b0;
      bias_reg     <= '0;
      acc_reg      <= '0;
      cfg_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      keep_reg     <= keep_next;
      len_reg      <= len_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      wt_len_reg   <= wt_len_next;
      wt_valid_reg <= wt_valid_next;
      bias_reg     <= bias_next;
      acc_reg      <= acc_next;
      cfg_err_reg  <= cfg_err_next;
    end
  end

  assign bus.cfg_ready = (state_reg == IDLE);
  assign bus.in_ready  = (state_reg == LOAD);
  assign bus.out_valid = (state_reg == OUTPUT);
  assign bus.pe_out    = (state_reg == OUTPUT) ? result : '0;
  assign bus.pe_busy   = (state_reg != IDLE);
  assign bus.cfg_err   = cfg_err_reg;
endmodule
